// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and constants for the commit trace buffer.
// The record struct is sized by the default widths. Narrower top-level
// parameters are zero-extended into it.
package trace_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int NR_GPR_DEF = 32;
    localparam int NR_CSR_DEF = 4;
    localparam int SEQ_W_DEF  = 16;
    localparam int GPR_AW_DEF = $clog2(NR_GPR_DEF);
    localparam int CSR_IW_DEF = (NR_CSR_DEF > 1) ? $clog2(NR_CSR_DEF) : 1;

    // Traced CSR slots
    localparam int CSR_MSTATUS = 0;
    localparam int CSR_MTVEC   = 1;
    localparam int CSR_MEPC    = 2;
    localparam int CSR_MCAUSE  = 3;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   pc;
        logic [31:0]           inst;
        logic                  rd_wen;
        logic [GPR_AW_DEF-1:0] rd_addr;
        logic [XLEN_DEF-1:0]   rd_data;
        logic                  csr_wen;
        logic [CSR_IW_DEF-1:0] csr_idx;
        logic [XLEN_DEF-1:0]   csr_data;
        logic                  skip;
        logic                  halt;
        logic [SEQ_W_DEF-1:0]  seq;
    } trace_rec_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side and consumer-side handshake bundle of the trace buffer.
// The slave modport is the buffer. The master modport is the core and consumer side.
interface commit_trace_buffer_if #(
    parameter int XLEN   = 64,
    parameter int NR_GPR = 32,
    parameter int NR_CSR = 4,
    parameter int SEQ_W  = 16
);
    localparam int GPR_AW = $clog2(NR_GPR);
    localparam int CSR_IW = (NR_CSR > 1) ? $clog2(NR_CSR) : 1;

    logic              cmt_valid;
    logic [XLEN-1:0]   cmt_pc;
    logic [31:0]       cmt_inst;
    logic              cmt_rd_wen;
    logic [GPR_AW-1:0] cmt_rd_addr;
    logic [XLEN-1:0]   cmt_rd_data;
    logic              cmt_csr_wen;
    logic [CSR_IW-1:0] cmt_csr_idx;
    logic [XLEN-1:0]   cmt_csr_data;
    logic              cmt_skip;
    logic              cmt_halt;
    logic              cmt_stall;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_inst;
    logic              out_rd_wen;
    logic [GPR_AW-1:0] out_rd_addr;
    logic [XLEN-1:0]   out_rd_data;
    logic              out_skip;
    logic              out_halt;
    logic [SEQ_W-1:0]  out_seq;

    modport slave (
        input  cmt_valid, cmt_pc, cmt_inst, cmt_rd_wen, cmt_rd_addr, cmt_rd_data,
               cmt_csr_wen, cmt_csr_idx, cmt_csr_data, cmt_skip, cmt_halt, out_ready,
        output cmt_stall, out_valid, out_pc, out_inst, out_rd_wen, out_rd_addr,
               out_rd_data, out_skip, out_halt, out_seq
    );

    modport master (
        output cmt_valid, cmt_pc, cmt_inst, cmt_rd_wen, cmt_rd_addr, cmt_rd_data,
               cmt_csr_wen, cmt_csr_idx, cmt_csr_data, cmt_skip, cmt_halt, out_ready,
        input  cmt_stall, out_valid, out_pc, out_inst, out_rd_wen, out_rd_addr,
               out_rd_data, out_skip, out_halt, out_seq
    );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Generic synchronous FIFO. Full is registered so that it has no path from pop.
// DEPTH must be a power of 2, so the pointers wrap naturally.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        full_q, full_d;
    logic                        push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && (count_q != '0);

    // Next pointers, occupancy and registered full flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Control state, cleared on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage. Stale entries are unreachable after reset, so there is no clear.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer. Queues retired-instruction records and drains them to
// the difftest consumer. Shadow PC, GPR and CSR state advance only as records
// drain, so the architectural view always matches the last drained record.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NR_GPR = NR_GPR_DEF,
    parameter int NR_CSR = NR_CSR_DEF,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = SEQ_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    commit_trace_buffer_if.slave    bus,
    output logic [XLEN-1:0]         arch_pc,
    output logic [NR_GPR*XLEN-1:0]  gpr_flat,
    output logic [NR_CSR*XLEN-1:0]  csr_flat,
    output logic [63:0]             retired,
    output logic                    overflow,
    output logic                    halted
);
    localparam int GPR_AW = $clog2(NR_GPR);
    localparam int REC_W  = $bits(trace_rec_t);

    trace_rec_t                   push_rec, head_rec;
    logic                         fifo_full, fifo_empty, push, pop;
    logic [$clog2(DEPTH):0]       fifo_count_unused;

    logic [SEQ_W-1:0]             seq_q, seq_d;
    logic [XLEN-1:0]              arch_pc_q, arch_pc_d;
    logic [NR_GPR-1:0][XLEN-1:0]  gpr_q, gpr_d;
    logic [NR_CSR-1:0][XLEN-1:0]  csr_q, csr_d;
    logic [63:0]                  retired_q, retired_d;
    logic                         overflow_q, overflow_d;
    logic                         halted_q, halted_d;

    // Accept a commit only with room and before a halt has drained
    assign push = bus.cmt_valid && !fifo_full && !halted_q;
    assign pop  = bus.out_valid && bus.out_ready;

    // Pack the commit-port fields into a tagged record
    always_comb begin
        push_rec          = '0;
        push_rec.pc       = XLEN_DEF'(bus.cmt_pc);
        push_rec.inst     = bus.cmt_inst;
        push_rec.rd_wen   = bus.cmt_rd_wen;
        push_rec.rd_addr  = GPR_AW_DEF'(bus.cmt_rd_addr);
        push_rec.rd_data  = XLEN_DEF'(bus.cmt_rd_data);
        push_rec.csr_wen  = bus.cmt_csr_wen;
        push_rec.csr_idx  = CSR_IW_DEF'(bus.cmt_csr_idx);
        push_rec.csr_data = XLEN_DEF'(bus.cmt_csr_data);
        push_rec.skip     = bus.cmt_skip;
        push_rec.halt     = bus.cmt_halt;
        push_rec.seq      = SEQ_W_DEF'(seq_q);
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_rec),
        .dout  (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    assign bus.cmt_stall   = fifo_full;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_pc      = XLEN'(head_rec.pc);
    assign bus.out_inst    = head_rec.inst;
    assign bus.out_rd_wen  = head_rec.rd_wen;
    assign bus.out_rd_addr = GPR_AW'(head_rec.rd_addr);
    assign bus.out_rd_data = XLEN'(head_rec.rd_data);
    assign bus.out_skip    = head_rec.skip;
    assign bus.out_halt    = head_rec.halt;
    assign bus.out_seq     = SEQ_W'(head_rec.seq);

    // Sequence tagging, sticky flags and shadow-state update on drain
    always_comb begin
        seq_d      = seq_q;
        arch_pc_d  = arch_pc_q;
        gpr_d      = gpr_q;
        csr_d      = csr_q;
        retired_d  = retired_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;

        if (push) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        if (bus.cmt_valid && fifo_full && !halted_q) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            arch_pc_d = XLEN'(head_rec.pc);
            retired_d = retired_q + 64'd1;
            if (head_rec.halt) begin
                halted_d = 1'b1;
            end
        end
        // Register 0 is never a target. An out-of-range CSR index matches no slot.
        for (int i = 1; i < NR_GPR; i++) begin
            if (pop && head_rec.rd_wen && head_rec.rd_addr == GPR_AW_DEF'(i)) begin
                gpr_d[i] = XLEN'(head_rec.rd_data);
            end
        end
        for (int j = 0; j < NR_CSR; j++) begin
            if (pop && head_rec.csr_wen && head_rec.csr_idx == CSR_IW_DEF'(j)) begin
                csr_d[j] = XLEN'(head_rec.csr_data);
            end
        end
    end

    // State registers, all cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_q      <= '0;
            arch_pc_q  <= '0;
            gpr_q      <= '0;
            csr_q      <= '0;
            retired_q  <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            arch_pc_q  <= arch_pc_d;
            gpr_q      <= gpr_d;
            csr_q      <= csr_d;
            retired_q  <= retired_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

    assign arch_pc  = arch_pc_q;
    assign gpr_flat = gpr_q;
    assign csr_flat = csr_q;
    assign retired  = retired_q;
    assign overflow = overflow_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer. Accepted commits are queued as
// expected records and compared at the head when the consumer pops them.
// A reference shadow state is updated on each pop.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        rd_wen;
        logic [4:0]  rd;
        logic [63:0] rdd;
        logic        csr_wen;
        logic [1:0]  ci;
        logic [63:0] cd;
        logic        skip;
        logic        halt;
        logic [15:0] seq;
    } rec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   arch_pc;
    logic [2047:0] gpr_flat;
    logic [255:0]  csr_flat;
    logic [63:0]   retired;
    logic          overflow, halted;

    commit_trace_buffer_if #(.XLEN(64), .NR_GPR(32), .NR_CSR(4), .SEQ_W(16)) bus ();

    commit_trace_buffer #(.XLEN(64), .NR_GPR(32), .NR_CSR(4), .DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .arch_pc  (arch_pc),
        .gpr_flat (gpr_flat),
        .csr_flat (csr_flat),
        .retired  (retired),
        .overflow (overflow),
        .halted   (halted)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;
    rec_t q[$];
    rec_t drv;
    logic [63:0] mgpr [32];
    logic [63:0] mcsr [4];
    logic [63:0] mret, mpc;
    logic [15:0] mseq;
    logic        movf, mhalt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        q.delete();
        foreach (mgpr[i]) mgpr[i] = '0;
        foreach (mcsr[i]) mcsr[i] = '0;
        mret = '0; mpc = '0; mseq = '0; movf = 0; mhalt = 0;
    endtask

    task automatic drive(input logic [63:0] pc, input logic rd_wen, input logic [4:0] rd,
                         input logic [63:0] rdd, input logic csr_wen, input logic [1:0] ci,
                         input logic [63:0] cd, input logic skip, input logic halt);
        drv = '{pc, pc[31:0] ^ 32'h0000_0013, rd_wen, rd, rdd, csr_wen, ci, cd, skip, halt, 16'h0};
        bus.cmt_valid = 1'b1;     bus.cmt_pc = pc;          bus.cmt_inst = drv.inst;
        bus.cmt_rd_wen = rd_wen;  bus.cmt_rd_addr = rd;     bus.cmt_rd_data = rdd;
        bus.cmt_csr_wen = csr_wen; bus.cmt_csr_idx = ci;    bus.cmt_csr_data = cd;
        bus.cmt_skip = skip;      bus.cmt_halt = halt;
    endtask

    task automatic idle();
        bus.cmt_valid = 1'b0;
    endtask

    // Check pre-edge outputs, advance the reference model, then cross the edge
    task automatic tick();
        rec_t r;
        bit   mpush, mpop;
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("cmt_stall", bus.cmt_stall, q.size() == DEPTH);
        chk("overflow", overflow, movf);
        chk("halted", halted, mhalt);
        chk("retired", retired, mret);
        chk("arch_pc", arch_pc, mpc);
        if (q.size() != 0 && bus.out_valid) begin
            chk("head_pc", bus.out_pc, q[0].pc);
            chk("head_inst", bus.out_inst, q[0].inst);
            chk("head_seq", bus.out_seq, q[0].seq);
            chk("head_rd", {bus.out_rd_wen, bus.out_rd_addr}, {q[0].rd_wen, q[0].rd});
            chk("head_rdd", bus.out_rd_data, q[0].rdd);
            chk("head_flags", {bus.out_skip, bus.out_halt}, {q[0].skip, q[0].halt});
        end
        mpop  = (q.size() != 0) && bus.out_ready;
        mpush = bus.cmt_valid && (q.size() < DEPTH) && !mhalt;
        if (!reset) begin
            if (bus.cmt_valid && q.size() == DEPTH && !mhalt) movf = 1;
            if (mpop) begin
                r = q.pop_front();
                if (r.rd_wen && r.rd != 0) mgpr[r.rd] = r.rdd;
                if (r.csr_wen) mcsr[r.ci] = r.cd;
                mpc = r.pc;
                mret++;
                if (r.halt) mhalt = 1;
            end
            if (mpush) begin
                r = drv;
                r.seq = mseq;
                q.push_back(r);
                mseq++;
            end
        end
        @(posedge clock); #1;
        if (reset) model_reset();
    endtask

    task automatic check_regs();
        for (int i = 0; i < 32; i++) chk($sformatf("gpr%0d", i), gpr_flat[i*64 +: 64], mgpr[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("csr%0d", i), csr_flat[i*64 +: 64], mcsr[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1; idle();
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_stall", bus.cmt_stall, 0);
        chk("rst_retired", retired, 0);
        check_regs();

        // First record: one-cycle latency, seq 0, shadow update one edge later
        drive(64'h8000_0000, 1, 5'd5, 64'hDEAD, 0, 0, 0, 0, 0); tick();
        idle();
        chk("first_valid", bus.out_valid, 1);
        chk("first_seq", bus.out_seq, 0);
        tick();
        chk("gpr5", gpr_flat[5*64 +: 64], 64'hDEAD);
        chk("first_pc", arch_pc, 64'h8000_0000);
        chk("first_ret", retired, 1);

        // Write to x0 is discarded
        drive(64'h8000_0004, 1, 5'd0, 64'hFFFF, 0, 0, 0, 0, 0); tick();
        idle(); tick(); tick();
        chk("gpr0", gpr_flat[63:0], 0);
        check_regs();

        // Fill to full, overflow on the ninth, then drain in order
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(64'h8000_1000 + 64'(i*4), 1, 5'(i + 1), 64'(i * 17), 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        chk("full_stall", bus.cmt_stall, 1);
        chk("ovf_set", overflow, 1);
        bus.out_ready = 1'b1;
        repeat (9) tick();
        chk("drain_ret", retired, 8);
        check_regs();

        // Continuous traffic with toggling ready
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.out_ready = i[0] ? 1'b0 : 1'b1;
            drive({32'h8000_2000, $urandom}, 1'($urandom), 5'($urandom), {$urandom, $urandom},
                  1'($urandom), 2'($urandom), {$urandom, $urandom}, 1'($urandom), 0);
            tick();
        end
        idle();
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("stream_empty", bus.out_valid, 0);
        check_regs();

        // GPR and CSR written by one record on one edge
        drive(64'h8000_3000, 1, 5'd10, 64'h1, 1, 2'd2, 64'h8000_0010, 0, 0); tick();
        idle(); tick();
        chk("dual_gpr10", gpr_flat[10*64 +: 64], 64'h1);
        chk("dual_mepc", csr_flat[2*64 +: 64], 64'h8000_0010);

        // Halt followed by queued records and further commits
        do_reset();
        bus.out_ready = 1'b0;
        drive(64'h8000_4000, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(64'h8000_4004, 1, 5'd3, 64'h33, 0, 0, 0, 1, 0); tick();
        drive(64'h8000_4008, 1, 5'd4, 64'h44, 0, 0, 0, 0, 0); tick();
        idle();
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(64'h8000_5000 + 64'(i*4), 1, 5'd9, 64'h99, 0, 0, 0, 0, 0);
            tick();
        end
        idle(); tick(); tick();
        chk("halt_flag", halted, 1);
        chk("halt_novf", overflow, 0);
        chk("halt_ret", retired, 3);
        check_regs();

        // Reset with records queued
        do_reset();
        drive(64'h8000_6000, 1, 5'd7, 64'h77, 1, 2'd0, 64'h5, 0, 0); tick();
        idle(); tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(64'h8000_7000 + 64'(i*4), 1, 5'd8, 64'h88, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rr_valid", bus.out_valid, 0);
        chk("rr_ret", retired, 0);
        chk("rr_pc", arch_pc, 0);
        check_regs();
        bus.out_ready = 1'b1;
        drive(64'h8000_8000, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("rr_seq", bus.out_seq, 0);
        tick(); tick();
        chk("end_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Parametrised successor to the difftest register-trace block.
- Captures one retired-instruction record per cycle from the core commit stage into a DEPTH-entry FIFO.
- Drains records to the DPI difftest consumer via valid/ready.
- Maintains shadow GPR/CSR/PC state, updated only as records drain, so the consumer always sees architectural state exactly consistent with the record just retired.

Parameters:
XLEN, 64, data/PC width
NR_GPR, 32, general registers (power of 2)
NR_CSR, 4, traced CSRs
DEPTH, 8, FIFO entries (power of 2, >=2)
SEQ_W, 16, record sequence-number width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
cmt_valid  in  1  retiring instruction this cycle
cmt_pc  in  XLEN  PC of retiring instruction
cmt_inst  in  32  instruction word
cmt_rd_wen  in  1  GPR write
cmt_rd_addr  in  log2(NR_GPR)  GPR index
cmt_rd_data  in  XLEN  GPR write data
cmt_csr_wen  in  1  traced-CSR write
cmt_csr_idx  in  max(1,log2(NR_CSR))  traced-CSR index
cmt_csr_data  in  XLEN  CSR write data
cmt_skip  in  1  MMIO access; consumer copies state instead of comparing
cmt_halt  in  1  ebreak/trap-halt instruction
cmt_stall  out  1  buffer full; core must hold commit
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head
out_pc, out_inst, out_rd_wen, out_rd_addr, out_rd_data, out_skip, out_halt  out  as cmt_*  head record fields
out_seq  out  SEQ_W  head record sequence number
arch_pc  out  XLEN  PC of last drained record
gpr_flat  out  NR_GPR*XLEN  shadow GPRs; reg i at bits [i*XLEN +: XLEN]
csr_flat  out  NR_CSR*XLEN  shadow CSRs, same packing
retired  out  64  drained-record count
overflow  out  1  sticky: commit arrived while full
halted  out  1  sticky: halt record drained

Behaviour:
- Clock is `clock`; reset is synchronous and active-high on `reset`.
- Reset (including mid-operation): pointers/count 0, seq 0.
  - out_valid, cmt_stall, overflow, halted = 0.
  - retired, arch_pc, all shadow regs = 0.
  - FIFO contents discarded.
- push = cmt_valid && !full && !halted. pop = out_valid && out_ready.
- cmt_stall = full, a registered-count decode with no combinational path from out_ready.
- Commit while full and !halted: record dropped, overflow set (sticky until reset).
- Commits while halted: silently ignored; no overflow, no seq advance.
- Latency: push in cycle N into an empty FIFO -> out_valid in N+1. No bypass.
- Push and pop in the same cycle: count unchanged; both pointers advance, wrapping mod DEPTH.
- Seq: each pushed record is tagged with a seq counter that increments per push and wraps mod 2^SEQ_W.
- out_* present the head entry. Values are don't-care when !out_valid; the bench must not check them then.
- On pop, at the following edge:
  - arch_pc <= out_pc.
  - retired += 1 (wraps at 2^64).
  - If out_rd_wen && out_rd_addr != 0: shadow GPR[rd] <= rd_data.
  - If csr_wen: shadow CSR[idx] <= csr_data. An idx >= NR_CSR is ignored.
  - If out_halt: halted <= 1.
  - A record carries both a GPR and a CSR write; both apply on the same edge.
- Shadow GPR 0 is constant zero.
- skip does not alter shadow-update rules; it is only carried to the consumer.
- A halt record still drains normally. Records queued behind it also drain.

Decomposition:
- Package trace_pkg:
  - XLEN/NR_GPR/NR_CSR defaults.
  - CSR index constants: MSTATUS=0, MTVEC=1, MEPC=2, MCAUSE=3.
  - Packed trace_rec_t struct: pc, inst, rd_wen/addr/data, csr_wen/idx/data, skip, halt, seq.
- One sub-module, trace_fifo: generic synchronous FIFO with WIDTH and DEPTH parameters, full/empty/count outputs, registered full.
- Top level holds seq counter, shadow state, sticky flags, retired counter.

Test Plan:
- Reset, then commit pc=0x80000000, rd=5, data=0xDEAD, out_ready=1 -> out_valid next cycle with out_seq=0; one edge later gpr[5]=0xDEAD, arch_pc=0x80000000, retired=1.
- Commit rd=0, data=0xFFFF -> drains; gpr[0] stays 0.
- out_ready=0, 8 back-to-back commits (DEPTH=8):
  - cmt_stall=1 after the 8th push.
  - A 9th cmt_valid sets overflow=1.
  - Release out_ready -> 8 records in seq 0..7, pc order preserved.
- Continuous push+pop for 20 cycles with out_ready toggling 1/0 -> no loss or duplication; pointer wrap; seq monotonic; retired equals records drained.
- Record with rd_wen=1 (rd=10, 0x1) and csr_wen=1 (MEPC, 0x80000010) -> both shadows update on the same edge.
- Halt record followed by 2 queued records and 3 further commits -> all queued records drain; halted=1 after the halt pops; later commits ignored; overflow stays 0.
- Reset asserted with 3 records queued -> next cycle out_valid=0, retired=0, shadows 0, seq restarts at 0.
